uart_tx: RTL and testbench
==========================

# uart_tx

Serial transmitter paired with the team's UART receiver: 8N1 framing, LSB first, idle-high line, same `CLKS_PER_BIT` baud convention (87 at the 10 MHz test clock, 115200 baud). A 4-entry byte FIFO sits in front of the shift state machine, so host logic can queue bytes back-to-back without tracking frame timing. Its output drives the board TX pin and, in loopback benches, the receiver's `i_Rx_Serial`.

## Interface
- `CLKS_PER_BIT`, 87: clock cycles per bit period; legal range ≥ 2.
- `FIFO_DEPTH`, 4: queued bytes; power of two, ≥ 2.
- `i_Clock`  in  1  single system clock; all logic is on its rising edge.
- `i_Reset_n`  in  1  asynchronous, active-low reset.
- `i_Tx_DV`  in  1  write strobe; a byte is accepted on an edge where `i_Tx_DV && o_Tx_Ready`.
- `i_Tx_Byte`  in  8  byte to queue, sampled with `i_Tx_DV`.
- `o_Tx_Ready`  out  1  FIFO not full.
- `o_Tx_Active`  out  1  high from the first start-bit cycle through the last stop-bit cycle.
- `o_Tx_Serial`  out  1  serial line, registered.
- `o_Tx_Done`  out  1  one-cycle pulse after each completed stop bit.

## Operation
- **Reset values (asynchronous):**
  - `o_Tx_Serial`=1, `o_Tx_Active`=0, `o_Tx_Done`=0, `o_Tx_Ready`=1.
  - FIFO empty, state IDLE, counters 0.
- **States:** IDLE, START, DATA, STOP, CLEANUP (3-bit encoding 0–4; any other value goes to IDLE).
- **IDLE:**
  - Line is 1, `r_Clock_Count`=0, `r_Bit_Index`=0.
  - If the FIFO is non-empty: pop the head into the shift register and go to START.
- **START:**
  - Line is 0 for exactly `CLKS_PER_BIT` cycles, counted 0..`CLKS_PER_BIT`-1.
  - Then clear the count and go to DATA.
- **DATA:**
  - Line carries `shift[r_Bit_Index]`, with each bit held `CLKS_PER_BIT` cycles.
  - Bit index runs 0..7; after bit 7, clear the index and go to STOP.
- **STOP:**
  - Line is 1 for `CLKS_PER_BIT` cycles.
  - On the last cycle, set `o_Tx_Done` and go to CLEANUP.
- **CLEANUP:** clear `o_Tx_Done` and go to IDLE unconditionally.
- **FIFO:**
  - Circular buffer with read/write pointers of width `$clog2(FIFO_DEPTH)`+1; full/empty are derived from pointer MSB compare.
  - Pointers wrap modulo `2*FIFO_DEPTH`.
- **Boundary conditions:**
  - Write while full (`o_Tx_Ready`=0): dropped, and the FIFO contents are unchanged.
  - Push and pop on the same edge when full: the push is still dropped, because ready was 0 during that cycle.
  - Push and pop on the same edge when partially full: both happen; occupancy is unchanged.
  - Push into an empty FIFO: the byte is visible to IDLE on the next edge. There is no combinational bypass.
  - `i_Tx_Byte` changing mid-frame has no effect on the frame, because the shift register was loaded at the pop.
  - Reset mid-frame: the line returns to 1 immediately (asynchronous), queued bytes are discarded, and no `o_Tx_Done` pulse is produced.
- **Counter width:** `$clog2(CLKS_PER_BIT)` bits; the count never exceeds `CLKS_PER_BIT`-1.

## Timing
- **Latency:** accept at edge N with the FIFO empty and state IDLE → pop at edge N+1 → `o_Tx_Serial`=0 and `o_Tx_Active`=1 from edge N+2.
- **Frame length:** start + 8 data + stop = `10*CLKS_PER_BIT` cycles of `o_Tx_Active`=1.
- **Done pulse:** `o_Tx_Done` is high for exactly 1 cycle, beginning on the edge after the final stop-bit cycle.
- **Back-to-back bytes:** the inter-frame gap is exactly 2 idle-high cycles (CLEANUP + IDLE). The stop bit therefore appears `CLKS_PER_BIT`+2 cycles long.
- **Ready timing:** `o_Tx_Ready` is registered-derived and updates on the edge after a push or pop.

## Structure
- **Shared package `uart_pkg`** holds:
  - state encodings `s_IDLE`..`s_CLEANUP`;
  - `CLKS_PER_BIT` default 87;
  - frame constants (8 data bits, 1 stop bit).
- The receiver imports the same package.
- **Sub-module `uart_tx_fifo`:**
  - parameter `FIFO_DEPTH`, width 8;
  - ports `i_Clock`, `i_Reset_n`, push/data-in, pop/data-out, full, empty;
  - the top level holds only the state machine and the shift register.

## Test plan
- **Reset idle:** assert `i_Reset_n`=0 for 3 cycles, then release → `o_Tx_Serial`=1, `o_Tx_Ready`=1, `o_Tx_Active`=0, `o_Tx_Done`=0; the line stays 1 for 2000 cycles with no writes.
- **Single byte:** write 0x55 → start bit 0, then line 1,0,1,0,1,0,1,0, then stop bit 1, each held 87 cycles. `o_Tx_Done` pulses once, 870 cycles after `o_Tx_Active` rises.
- **Loopback:** connect to the UART receiver and send 0xA3 → the receiver asserts `o_Rx_DV` with `o_Rx_Byte`=0xA3.
- **Queue and overflow:**
  - write 0x01,0x02,0x03,0x04,0x05 on 5 consecutive cycles;
  - the first byte is popped immediately, so `o_Tx_Ready` stays 1 and all 5 writes are accepted;
  - a 6th write of 0x06 is dropped (`o_Tx_Ready`=0);
  - the line carries 0x01..0x05 in order, with 2-cycle gaps, and 5 `o_Tx_Done` pulses.
- **Reset mid-frame:**
  - with 2 bytes queued, pull `i_Reset_n` low during data bit 3 → `o_Tx_Serial`=1 within the same cycle;
  - after release, the FIFO is empty, no Done pulse occurs, and a fresh write of 0xFF transmits correctly.
- **Boundary parameter:** `CLKS_PER_BIT`=2, byte 0x80 → 20-cycle frame, with bit 7 high for exactly 2 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ==== uart_pkg -- shared UART framing constants and state encodings (rev 1.0) ====

package uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 87;
  localparam int FIFO_DEPTH_DEFAULT   = 4;
  localparam int DATA_BITS            = 8;
  localparam int STOP_BITS            = 1;
  localparam int STATE_W              = 3;

  localparam logic [2:0] s_IDLE    = 3'd0;
  localparam logic [2:0] s_START   = 3'd1;
  localparam logic [2:0] s_DATA    = 3'd2;
  localparam logic [2:0] s_STOP    = 3'd3;
  localparam logic [2:0] s_CLEANUP = 3'd4;

  // True for the states during which a frame is on the line.
  function automatic logic is_frame_state(input logic [STATE_W-1:0] state);
    return (state == s_START) || (state == s_DATA) || (state == s_STOP);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ==== uart_tx_fifo -- circular byte FIFO, full/empty from pointer MSB compare (rev 1.0) ====

module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int WIDTH      = DATA_BITS
) (
  input  logic             i_Clock,
  input  logic             i_Reset_n,
  input  logic             i_Push,
  input  logic [WIDTH-1:0] i_Data,
  input  logic             i_Pop,
  output logic [WIDTH-1:0] o_Data,
  output logic             o_Full,
  output logic             o_Empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] c_PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic             push_ok;
  logic             pop_ok;

  // The extra pointer bit distinguishes full from empty when the indices match.
  assign o_Full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign o_Empty = (wr_ptr_q == rd_ptr_q);
  assign o_Data  = mem_q[rd_ptr_q[AW-1:0]];

  assign push_ok = i_Push && !o_Full;
  assign pop_ok  = i_Pop && !o_Empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + c_PTR_ONE;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + c_PTR_ONE;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= i_Data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ==== uart_tx -- 8N1 LSB-first serial transmitter fed by a byte FIFO (rev 1.0) ====

module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEFAULT
) (
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Ready,
  output logic       o_Tx_Active,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] c_LAST_COUNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] c_COUNT_ONE  = CW'(1);
  localparam logic [2:0]    c_LAST_DATA  = 3'(DATA_BITS - 1);
  localparam logic [2:0]    c_LAST_STOP  = 3'(STOP_BITS - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic               serial_q, serial_d;
  logic               active_q, active_d;
  logic               done_q, done_d;

  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [7:0]         fifo_data;
  logic               bit_end;

  uart_tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (8)
  ) u_fifo (
    .i_Clock   (i_Clock),
    .i_Reset_n (i_Reset_n),
    .i_Push    (i_Tx_DV),
    .i_Data    (i_Tx_Byte),
    .i_Pop     (fifo_pop),
    .o_Data    (fifo_data),
    .o_Full    (fifo_full),
    .o_Empty   (fifo_empty)
  );

  assign bit_end = (count_q == c_LAST_COUNT);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    fifo_pop  = 1'b0;

    case (state_q)
      s_IDLE: begin
        count_d   = '0;
        bit_idx_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_data;
          state_d  = s_START;
        end
      end

      s_START: begin
        if (bit_end) begin
          count_d = '0;
          state_d = s_DATA;
        end else begin
          count_d = count_q + c_COUNT_ONE;
        end
      end

      s_DATA: begin
        if (bit_end) begin
          count_d = '0;
          if (bit_idx_q == c_LAST_DATA) begin
            bit_idx_d = '0;
            state_d   = s_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          count_d = count_q + c_COUNT_ONE;
        end
      end

      s_STOP: begin
        if (bit_end) begin
          count_d = '0;
          if (bit_idx_q == c_LAST_STOP) begin
            bit_idx_d = '0;
            state_d   = s_CLEANUP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          count_d = count_q + c_COUNT_ONE;
        end
      end

      s_CLEANUP: begin
        state_d = s_IDLE;
      end

      default: begin
        state_d   = s_IDLE;
        count_d   = '0;
        bit_idx_d = '0;
      end
    endcase
  end

  // Outputs are registered from the current state, so the line trails the
  // state register by one edge; Done lands on the edge after the last stop cycle.
  always_comb begin
    serial_d = 1'b1;
    active_d = is_frame_state(state_q);
    done_d   = (state_q == s_CLEANUP);
    case (state_q)
      s_START: serial_d = 1'b0;
      s_DATA:  serial_d = shift_q[bit_idx_q];
      default: serial_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q   <= s_IDLE;
      count_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      serial_q  <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      serial_q  <= serial_d;
      active_q  <= active_d;
      done_q    <= done_d;
    end
  end

  assign o_Tx_Ready  = !fifo_full;
  assign o_Tx_Active = active_q;
  assign o_Tx_Serial = serial_q;
  assign o_Tx_Done   = done_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ==== tb_uart_tx -- scoreboard bench: stimulus queues expected frames, monitor decodes the line ====

module tb_uart_tx;

  localparam int CPB        = 87;
  localparam int DEPTH      = 4;
  localparam int FRAME      = 10 * CPB;
  localparam int POP_PERIOD = FRAME + 2;
  localparam int CPB2       = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dv = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       ready, active, serial, done;
  logic       dv2 = 1'b0;
  logic [7:0] tx_byte2 = 8'h00;
  logic       ready2, active2, serial2, done2;

  always #50 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .i_Clock     (clk),
    .i_Reset_n   (rst_n),
    .i_Tx_DV     (dv),
    .i_Tx_Byte   (tx_byte),
    .o_Tx_Ready  (ready),
    .o_Tx_Active (active),
    .o_Tx_Serial (serial),
    .o_Tx_Done   (done)
  );

  uart_tx #(.CLKS_PER_BIT(CPB2), .FIFO_DEPTH(DEPTH)) dut2 (
    .i_Clock     (clk),
    .i_Reset_n   (rst_n),
    .i_Tx_DV     (dv2),
    .i_Tx_Byte   (tx_byte2),
    .o_Tx_Ready  (ready2),
    .o_Tx_Active (active2),
    .o_Tx_Serial (serial2),
    .o_Tx_Done   (done2)
  );

  typedef struct {
    logic [7:0] data;
    int         start_edge;
  } frame_t;

  int     n_vec = 0;
  int     n_err = 0;
  int     edge_cnt = 0;
  frame_t exp_q[$];
  int     pop_edges[$];
  int     last_pop = -1000000;
  int     last_start = 0;
  int     idle_viol = 0;
  int     spurious_done = 0;
  int     frames_seen = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bytes still in the FIFO just before edge e: accepted but not yet popped.
  function automatic int occupancy(input int e);
    int n = 0;
    foreach (pop_edges[i]) if (pop_edges[i] >= e) n++;
    return n;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    pop_edges.delete();
    last_pop = -1000000;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called just after a rising edge; the write is sampled on the next edge.
  task automatic send(input logic [7:0] b);
    int   e;
    int   p;
    logic exp_rdy;
    e       = edge_cnt + 1;
    exp_rdy = (occupancy(e) < DEPTH);
    dv      = 1'b1;
    tx_byte = b;
    @(negedge clk);
    chk($sformatf("ready_at_write_%02h", b), ready, exp_rdy);
    if (exp_rdy) begin
      p = (e + 1 > last_pop + POP_PERIOD) ? e + 1 : last_pop + POP_PERIOD;
      last_pop = p;
      pop_edges.push_back(p);
      exp_q.push_back('{b, p + 1});
      last_start = p + 1;
    end
    @(posedge clk);
    #1;
    dv      = 1'b0;
    tx_byte = 8'($urandom);
  endtask

  task automatic drain();
    int budget;
    int n;
    budget = (exp_q.size() + 2) * POP_PERIOD;
    n = 0;
    while ((exp_q.size() > 0 || active === 1'b1) && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("drain_in_time", (n < budget), 1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    frame_t     f;
    logic [9:0] bits;
    int         k, match, act_cycles;
    logic       aborted;
    forever begin
      @(negedge clk);
      if (!rst_n) continue;
      if (active !== 1'b1) begin
        if (done === 1'b1) spurious_done++;
        if (serial !== 1'b1) idle_viol++;
        continue;
      end
      k = edge_cnt;
      chk("frame_expected", (exp_q.size() > 0), 1);
      if (exp_q.size() == 0) begin
        while (active === 1'b1 && rst_n) @(negedge clk);
        continue;
      end
      f          = exp_q.pop_front();
      bits       = {1'b1, f.data, 1'b0};
      aborted    = 1'b0;
      act_cycles = 0;
      chk($sformatf("start_edge_%02h", f.data), k, f.start_edge);
      for (int b = 0; b < 10 && !aborted; b++) begin
        match = 0;
        for (int c = 0; c < CPB; c++) begin
          if (b > 0 || c > 0) @(negedge clk);
          if (!rst_n) begin
            aborted = 1'b1;
            break;
          end
          if (serial === bits[b]) match++;
          if (active === 1'b1) act_cycles++;
          if (done === 1'b1) spurious_done++;
        end
        if (!aborted) chk($sformatf("bit%0d_cycles_%02h", b, f.data), match, CPB);
      end
      if (!aborted) begin
        chk($sformatf("active_cycles_%02h", f.data), act_cycles, FRAME);
        @(negedge clk);
        chk($sformatf("done_high_%02h", f.data), done, 1);
        chk($sformatf("active_low_%02h", f.data), active, 0);
        @(negedge clk);
        chk($sformatf("done_cleared_%02h", f.data), done, 0);
        chk($sformatf("gap_line_%02h", f.data), serial, 1);
        frames_seen++;
      end
    end
  end

  initial begin : stim
    int f0, sd0, tgt, first_start;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_serial", serial, 1);
    chk("rst_ready", ready, 1);
    chk("rst_active", active, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    idle_cycles(2000);
    chk("idle_line_2000", idle_viol, 0);
    chk("idle_done_2000", spurious_done, 0);

    // Minimum bit period on the second instance, checked cycle by cycle.
    for (int t = 0; t < 6; t++) begin
      logic [7:0]  b2;
      logic [9:0]  fr;
      logic [29:0] got_line, got_act, got_done, exp_line, exp_act, exp_done;
      b2       = (t == 0) ? 8'h80 : 8'($urandom);
      fr       = {1'b1, b2, 1'b0};
      dv2      = 1'b1;
      tx_byte2 = b2;
      @(posedge clk);
      #1;
      dv2      = 1'b0;
      tx_byte2 = ~b2;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        got_line[i] = serial2;
        got_act[i]  = active2;
        got_done[i] = done2;
        exp_line[i] = (i >= 2 && i < 22) ? fr[(i - 2) / 2] : 1'b1;
        exp_act[i]  = (i >= 2 && i < 22);
        exp_done[i] = (i == 22);
      end
      chk($sformatf("cpb2_line_%02h", b2), got_line, exp_line);
      chk($sformatf("cpb2_active_%02h", b2), got_act, exp_act);
      chk($sformatf("cpb2_done_%02h", b2), got_done, exp_done);
      @(posedge clk);
      #1;
    end

    send(8'h55);
    drain();
    chk("single_frames", frames_seen, 1);

    send(8'hA3);
    drain();

    f0 = frames_seen;
    for (int i = 1; i <= 6; i++) send(8'(i));
    drain();
    chk("queue_frames", frames_seen - f0, 5);

    send(8'h35);
    first_start = last_start;
    send(8'hC3);
    send(8'h5A);
    tgt = first_start + 4 * CPB + CPB / 2;
    while (edge_cnt < tgt) begin
      @(posedge clk);
      #1;
    end
    chk("bit3_before_reset", serial, 0);
    f0    = frames_seen;
    sd0   = spurious_done;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("reset_line_async", serial, 1);
    chk("reset_active_async", active, 0);
    chk("reset_ready_async", ready, 1);
    idle_cycles(3);
    rst_n = 1'b1;
    idle_cycles(3 * FRAME);
    chk("no_frames_after_reset", frames_seen - f0, 0);
    chk("no_done_after_reset", spurious_done - sd0, 0);
    send(8'hFF);
    drain();

    for (int it = 0; it < 10; it++) begin
      int n;
      n = $urandom_range(1, 5);
      for (int j = 0; j < n; j++) send(8'($urandom));
      idle_cycles($urandom_range(0, 2 * FRAME));
    end
    drain();

    chk("idle_line_total", idle_viol, 0);
    chk("spurious_done_total", spurious_done, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #(95000 * 100);
    $display("FAIL watchdog: simulation exceeded cycle budget, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
